// File: rtl/pipe_issue_arbiter.sv
// pipe_issue_arbiter: round-robin issue of NREQ requesters into one shared
// fixed-latency pipelined datapath, with per-requester credit limits and a
// requester-ID tag pipe that steers each result back to its issuer.

// Per-requester in-flight counter; avail_o drops once MAX_OUT ops are in flight.
module pipe_issue_credit #(
   parameter int MAX_OUT = 2,
   parameter int CW      = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          inc_i,
   input  logic          dec_i,
   output logic          avail_o,
   output logic [CW-1:0] cnt_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: a simultaneous issue and response cancel out.
   always_comb begin
      cnt_d = cnt_q;
      case ({inc_i, dec_i})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Counter register; inc/dec are already zero while the pipe is frozen.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Uses the registered count, so a credit freed this cycle is usable next cycle.
   assign avail_o = (cnt_q < CW'(MAX_OUT));
   assign cnt_o   = cnt_q;

endmodule

module pipe_issue_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 256,
   parameter int LATENCY = 8,
   parameter int MAX_OUT = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              gwe_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ*W-1:0] req_data_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic              pipe_in_valid_o,
   output logic [W-1:0]      pipe_in_data_o,
   input  logic [W-1:0]      pipe_out_data_i,
   output logic [NREQ-1:0]   resp_valid_o,
   output logic [W-1:0]      resp_data_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_OUT + 1);

   logic [NREQ-1:0]         credit_ok;
   logic [NREQ-1:0][CW-1:0] outstanding;
   logic [NREQ-1:0]         elig;
   logic [NREQ-1:0]         gnt;
   logic [NREQ-1:0]         resp_vld;
   logic                    gnt_any;
   logic [PW-1:0]           gnt_id;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [W-1:0]            issue_data;

   // Tag pipe: valid and requester id of every op inside the datapath.
   logic [LATENCY-1:0]          vld_pipe_q;
   logic [LATENCY-1:0][PW-1:0]  id_pipe_q;

   // One credit counter per requester.
   for (genvar i = 0; i < NREQ; i++) begin : g_credit
      pipe_issue_credit #(
         .MAX_OUT (MAX_OUT),
         .CW      (CW)
      ) u_credit (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .inc_i   (gnt[i]),
         .dec_i   (resp_vld[i]),
         .avail_o (credit_ok[i]),
         .cnt_o   (outstanding[i])
      );
   end

   // Requests that may be granted this cycle; nothing is granted while frozen or in reset.
   assign elig = req_valid_i & credit_ok & {NREQ{gwe_i & ~rst_i}};

   // Round-robin pick: first eligible index scanning upward from ptr, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         idx = (int'(ptr_q) + off) % NREQ;
         if (!gnt_any && elig[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = PW'(idx);
            gnt_any  = 1'b1;
         end
      end
   end

   // Pointer advances past the grantee; holds when nothing is granted.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + PW'(1);
   end

   // Operand mux; zero when nobody is granted.
   always_comb begin
      issue_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) issue_data = issue_data | req_data_i[i*W +: W];
      end
   end

   // Arbitration pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i)      ptr_q <= '0;
      else if (gwe_i) ptr_q <= ptr_d;
   end

   // Tag pipe advances in lock-step with the datapath; reset discards in-flight ops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe_q <= '0;
         id_pipe_q  <= '0;
      end else if (gwe_i) begin
         for (int s = LATENCY - 1; s >= 1; s--) begin
            vld_pipe_q[s] <= vld_pipe_q[s-1];
            id_pipe_q[s]  <= id_pipe_q[s-1];
         end
         vld_pipe_q[0] <= gnt_any;
         id_pipe_q[0]  <= gnt_id;
      end
   end

   // Decode the tag leaving the pipe into a one-hot response strobe.
   always_comb begin
      resp_vld = '0;
      if (vld_pipe_q[LATENCY-1] && gwe_i) resp_vld[id_pipe_q[LATENCY-1]] = 1'b1;
   end

   assign req_ready_o     = gnt;
   assign pipe_in_valid_o = gnt_any;
   assign pipe_in_data_o  = issue_data;
   assign resp_valid_o    = resp_vld;
   assign resp_data_o     = pipe_out_data_i;

endmodule
